// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end: constants,
// fetch FSM encoding, buffer entry layout and small address helpers.
package riscv_pkg;

  // Canonical RV32I NOP (addi x0, x0, 0) shown to decode when nothing is valid
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned BUF_DEPTH        = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential fetch address, wrapping naturally at the top of the space
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer holding {pc, instr} pairs between
// the memory response and the decode stage. Flush empties it in one cycle.
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  fetch_entry_t mem_q [BUF_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Next pointer/count values; flush wins over push and pop
  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a write into a full buffer only happens alongside a pop
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '{pc: 32'h0000_0000, instr: NOP_INSTR};
      end
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches under a two-slot credit,
// buffers in-order responses for decode, and handles redirects by dropping
// responses to requests already in flight.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [1:0]   outs_q;
  logic [1:0]   discard_q, discard_d;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic [1:0]   buf_count;
  logic         buf_valid;
  logic         pop;
  logic         in_fetch;
  logic         active;
  logic [2:0]   occupancy;
  logic         req;
  logic         accept;
  logic         rsp_live;
  logic         rsp_drop;
  logic         push;
  logic         flush;
  logic [31:0]  resp_pc;

  // Handshake, credit and bookkeeping terms derived from current state
  always_comb begin
    buf_valid  = (buf_count != 2'd0);
    pop        = buf_valid && instr_ready;
    in_fetch   = (state_q == S_FETCH);
    active     = (state_q != S_IDLE);
    // Slots already promised: in flight plus buffered, less what leaves now
    occupancy  = {1'b0, outs_q} + {1'b0, buf_count} - {2'b00, pop};
    req        = in_fetch && (occupancy < 3'd2);
    accept     = req && imem_ready;
    rsp_live   = imem_rvalid && (outs_q != 2'd0);
    rsp_drop   = imem_rvalid && ((discard_q != 2'd0) || (outs_q != 2'd0));
    push       = in_fetch && !redirect && rsp_live;
    flush      = active && redirect;
    // Requests issue at consecutive words, so the oldest one in flight sits
    // outs_q words behind the next fetch address
    resp_pc    = fetch_pc_q - {28'd0, outs_q, 2'b00};
    push_entry = '{pc: resp_pc, instr: imem_rdata};
    // Responses still owed after a redirect, less the one arriving now
    discard_d  = discard_q + outs_q + {1'b0, accept} - {1'b0, rsp_drop};
  end

  // Fetch FSM with fetch PC, in-flight and discard counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      outs_q     <= 2'd0;
      discard_q  <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (redirect) begin
            fetch_pc_q <= align_word(redirect_pc);
            outs_q     <= 2'd0;
            discard_q  <= discard_d;
            state_q    <= (discard_d != 2'd0) ? S_FLUSH : S_FETCH;
          end else begin
            if (accept) begin
              fetch_pc_q <= next_word(fetch_pc_q);
            end else begin
              fetch_pc_q <= fetch_pc_q;
            end
            outs_q <= outs_q + {1'b0, accept} - {1'b0, rsp_live};
          end
        end
        S_FLUSH: begin
          if (redirect) begin
            fetch_pc_q <= align_word(redirect_pc);
            discard_q  <= discard_d;
            state_q    <= (discard_d != 2'd0) ? S_FLUSH : S_FETCH;
          end else if (rsp_drop) begin
            discard_q <= discard_d;
            state_q   <= (discard_d != 2'd0) ? S_FLUSH : S_FETCH;
          end else begin
            discard_q <= discard_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (flush),
    .head_o       (head),
    .count_o      (buf_count)
  );

  assign imem_req    = req;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = buf_valid;
  assign instr       = buf_valid ? head.instr : NOP_INSTR;
  assign instr_pc    = buf_valid ? head.pc : RESET_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // stimulus knobs (percentages and memory latency range)
  int ready_pct = 100, ird_pct = 100, rv_pct = 100;
  int redir_pct = 0, stray_pct = 0, lat_min = 1, lat_max = 1;

  // reference model: buffered {pc,instr}, addresses in flight, owed drops
  logic [63:0] m_buf[$];
  logic [31:0] m_addr_q[$];
  int          m_disc     = 0;
  logic [31:0] m_pc       = RST_PC;
  bit          m_live     = 1'b0;
  bit          m_draining = 1'b0;

  // memory: due cycle of each accepted request, in order
  int mem_due[$];

  bit          last_valid, last_req;
  logic [31:0] last_pc, last_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit force_redir, input logic [31:0] force_pc);
    bit          mem_resp, m_pop, m_req, acc, e_valid;
    logic [31:0] e_instr, e_pc, a;
    int          owed;
    @(negedge clk);
    reset       = rst;
    imem_ready  = ($urandom_range(99) < ready_pct);
    instr_ready = ($urandom_range(99) < ird_pct);
    mem_resp    = (mem_due.size() != 0) && (mem_due[0] <= cyc) && ($urandom_range(99) < rv_pct);
    imem_rdata  = $urandom;
    if (mem_resp) imem_rvalid = 1'b1;
    else imem_rvalid = (mem_due.size() == 0) && (m_addr_q.size() == 0) && (m_disc == 0)
                       && ($urandom_range(99) < stray_pct);
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
    end else begin
      redirect    = ($urandom_range(99) < redir_pct);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    end
    #1;
    m_pop   = (m_buf.size() != 0) && instr_ready;
    m_req   = m_live && !m_draining && ((m_addr_q.size() + m_buf.size() - int'(m_pop)) < 2);
    e_valid = (m_buf.size() != 0);
    e_instr = e_valid ? m_buf[0][31:0] : NOP;
    e_pc    = e_valid ? m_buf[0][63:32] : RST_PC;
    check_eq("imem_req", 32'(imem_req), 32'(m_req));
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
    check_eq("instr", instr, e_instr);
    check_eq("instr_pc", instr_pc, e_pc);
    last_valid = instr_valid;
    last_req   = imem_req;
    last_pc    = instr_pc;
    last_addr  = imem_addr;

    acc = m_req && imem_ready;
    if (mem_resp) void'(mem_due.pop_front());
    if (acc) mem_due.push_back(cyc + lat_min + int'($urandom_range(lat_max - lat_min)));

    if (rst) begin
      m_live = 1'b0; m_draining = 1'b0; m_pc = RST_PC; m_disc = 0;
      m_buf.delete(); m_addr_q.delete(); mem_due.delete();
    end else if (!m_live) begin
      m_live = 1'b1;
    end else if (redirect) begin
      owed = m_disc + m_addr_q.size();
      if (imem_rvalid && owed > 0) owed--;
      owed += int'(acc);
      m_disc = owed;
      m_draining = (owed != 0);
      m_addr_q.delete();
      m_buf.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else if (m_draining) begin
      if (imem_rvalid && m_disc > 0) begin
        m_disc--;
        if (m_disc == 0) m_draining = 1'b0;
      end
    end else begin
      if (m_pop) void'(m_buf.pop_front());
      if (imem_rvalid && m_addr_q.size() > 0) begin
        a = m_addr_q.pop_front();
        m_buf.push_back({a, imem_rdata});
      end
      if (acc) begin
        m_addr_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    int edges;
    bit hit;
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

    // reset, then 1-cycle memory with full throughput
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check_eq("rst_pc", last_pc, RST_PC);
    check_eq("rst_addr", last_addr, RST_PC);
    edges = 99;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (last_valid) begin edges = k; break; end
    end
    check_eq("first_valid_edges", 32'(edges), 32'd3);
    repeat (20) step(1'b0, 1'b0, 32'h0);

    // decode stalls for 10 cycles, then drains
    ird_pct = 0;
    repeat (10) step(1'b0, 1'b0, 32'h0);
    check_eq("bp_req", 32'(last_req), 32'd0);
    check_eq("bp_valid", 32'(last_valid), 32'd1);
    ird_pct = 100;
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // redirect with two requests in flight and 3-cycle memory
    lat_min = 3; lat_max = 3;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_addr_q.size() == 2) begin hit = 1'b1; break; end
      step(1'b0, 1'b0, 32'h0);
    end
    check_eq("redir_setup", 32'(hit), 32'd1);
    step(1'b0, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b0, 32'h0);
    check_eq("redir_addr", last_addr, 32'h0000_0100);
    hit = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (last_valid) begin hit = 1'b1; break; end
    end
    check_eq("redir_seen", 32'(hit), 32'd1);
    check_eq("redir_first_pc", last_pc, 32'h0000_0100);

    // redirect in steady state (coincident rvalid and handshake), near wrap
    lat_min = 1; lat_max = 1;
    repeat (8) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    hit = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (last_req && last_addr == 32'h0000_0000) begin hit = 1'b1; break; end
    end
    check_eq("wrap_to_zero", 32'(hit), 32'd1);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // reset with two in flight, stray responses afterwards
    lat_min = 4; lat_max = 4;
    for (int k = 0; k < 20; k++) begin
      if (m_addr_q.size() == 2) break;
      step(1'b0, 1'b0, 32'h0);
    end
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    stray_pct = 100; ready_pct = 0;
    repeat (4) step(1'b0, 1'b0, 32'h0);
    check_eq("stray_valid", 32'(last_valid), 32'd0);
    check_eq("stray_pc", last_pc, RST_PC);
    stray_pct = 0; ready_pct = 100; lat_min = 1; lat_max = 1;
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int blk = 0; blk < 30; blk++) begin
      ready_pct = 40 + int'($urandom_range(60));
      ird_pct   = 30 + int'($urandom_range(70));
      rv_pct    = 50 + int'($urandom_range(50));
      redir_pct = int'($urandom_range(8));
      stray_pct = int'($urandom_range(20));
      lat_min   = 1 + int'($urandom_range(2));
      lat_max   = lat_min + int'($urandom_range(3));
      for (int k = 0; k < 100; k++) step($urandom_range(199) == 0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
